lfsr_piece_gen: RTL and testbench
=================================

Name: lfsr_piece_gen

Overview:
- Parametrised XNOR-feedback Fibonacci LFSR with a request/acknowledge sampler that returns a uniform value in 0..RANGE-1.
- Used by the Tetris game logic for next-piece selection (RANGE=7).
- Replaces fixed 2-bit LFSR usage. Adds:
  - configurable width and taps
  - seed load
  - enable gating
  - rejection sampling with bounded retries
  - valid/ack handshake

Parameters:
- WIDTH, 16: LFSR state width, 2..32.
- TAPS, 16'hB400: feedback mask; bit i set means state[i] feeds the XNOR.
- RANGE, 7: output value count, 2..2^OUT_W.
- MAX_TRIES, 4: SAMPLE evaluations before forced delivery, at least 1.

Ports:
- clk, in, 1: rising-edge clock.
- data_A, in, 1: reset, asynchronous, active-high.
- en, in, 1: advance the LFSR this cycle.
- seed_load, in, 1: load seed_in this cycle.
- seed_in, in, WIDTH: seed value.
- req, in, 1: request a new value.
- ack, in, 1: consumer accepted rnd_value.
- lfsr_out, out, WIDTH: current LFSR state.
- rnd_valid, out, 1: rnd_value is valid.
- rnd_value, out, OUT_W: sampled value.
- busy, out, 1: state is not IDLE.

Behaviour:
- OUT_W = clog2(RANGE), with a minimum of 1.
- Reset is asynchronous, active-high on data_A. On reset:
  - lfsr_out = 0, rnd_valid = 0, rnd_value = 0, busy = 0
  - state = IDLE, try count = 0, last value = 0
- LFSR, each posedge, in priority order:
  - seed_load = 1: state <= seed_in. If seed_in is all-ones (the XNOR lock-up state), load 0 instead.
  - else en = 1: state <= {state[WIDTH-2:0], fb}, where fb = ~^(state & TAPS).
  - else: hold.
- The LFSR runs independently of the FSM; en gates only the LFSR.
- Candidate: cand = lfsr_out[OUT_W-1:0], the current registered state.
- FSM states are IDLE, SAMPLE and HOLD.
  - IDLE: req = 1 -> SAMPLE, try count cleared. busy = 0.
  - SAMPLE: evaluates cand every cycle.
    - If cand < RANGE: rnd_value <= cand, rnd_valid <= 1, go to HOLD.
    - Else, if try count == MAX_TRIES-1: force delivery of cand - RANGE, which is always < RANGE because RANGE > 2^(OUT_W-1). rnd_valid <= 1, go to HOLD.
    - Else: try count++ and stay in SAMPLE.
  - HOLD: rnd_valid = 1, rnd_value stable.
    - ack = 1 -> rnd_valid <= 0, go to IDLE, last value <= rnd_value.
    - ack while not in HOLD is ignored.
- Latency: req high in cycle N, accepted in SAMPLE at cycle N+1 -> rnd_valid high from cycle N+2.
  - Each rejection adds 1 cycle.
  - Worst case is MAX_TRIES+1 cycles.
- req is ignored outside IDLE; it must be re-asserted after ack.
- req and ack in the same cycle while in HOLD: ack is taken and req is ignored.
- Simultaneous seed_load and an active SAMPLE: the FSM evaluates the pre-load state that cycle and the loaded seed the next cycle.
- Reset mid-operation clears everything immediately. No partial handshake survives.

Optional Feature:
- Macro: LFSR_PIECE_NO_REPEAT_EN.
- When defined, in SAMPLE a cand < RANGE that equals last value is rejected once per request ("reroll once").
  - The reroll consumes one try and sets a per-request reroll flag.
  - A later match is accepted.
  - A forced delivery ignores the reroll check.
  - The reroll flag is cleared on entry to SAMPLE.
- When undefined, last value is not implemented and any cand < RANGE is accepted immediately.

Decomposition:
- Shared package (lfsr_pkg):
  - FSM state encodings: IDLE = 2'd0, SAMPLE = 2'd1, HOLD = 2'd2.
  - Default TAPS constants for widths 8, 16 and 32.
  - A clog2 helper.
- Sub-module lfsr_core (parameters WIDTH and TAPS; ports clk, data_A, en, seed_load, seed_in, state):
  - Contains the shift/XNOR datapath and the lock-up guard.
  - lfsr_piece_gen instantiates it and holds only the FSM and sampling.

Test Plan:
- Reset, then en = 1 with no load (defaults): lfsr_out = 16'h0001, 16'h0003, 16'h0007 after steps 1-3, and 16'h0FFE after step 12.
- seed_load with seed_in = 16'hFFFF: lfsr_out = 16'h0000 next cycle (lock-up guard).
- seed_in = 16'h0005 loaded, en = 0, req pulse at cycle N: rnd_valid = 1 and rnd_value = 5 at N+2, held until ack; busy low the cycle after ack.
- seed_in = 16'h0007 loaded, en = 0, MAX_TRIES = 4, req pulse: 4 SAMPLE cycles, then forced rnd_value = 0; rnd_valid at N+5.
- With LFSR_PIECE_NO_REPEAT_EN defined: seed 16'h0005, en = 0, deliver 5, ack, req again: first evaluation is rerolled, value 5 delivered one cycle later than otherwise (N+3).
- Assert data_A during SAMPLE and during HOLD: rnd_valid, busy and lfsr_out go to 0 immediately; a req after deassert behaves as from a fresh reset.

Source files
------------

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Purpose  : Shared FSM encodings, default feedback masks and clog2 helper
//            for the LFSR piece generator.
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(value)) r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_core
// Purpose  : XNOR-feedback Fibonacci LFSR with seed load, enable gating and
//            all-ones lock-up guard on the seed path.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_16)
) (
    input  logic             clk,
    input  logic             data_A,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] r_state;
    logic             w_fb;
    logic [WIDTH-1:0] w_seed;

    assign w_fb   = ~^(r_state & TAPS);
    // All-ones never leaves an XNOR LFSR, so it is substituted with zero.
    assign w_seed = (&seed_in) ? '0 : seed_in;

    always_ff @(posedge clk or posedge data_A) begin
        if (data_A) begin
            r_state <= '0;
        end else if (seed_load) begin
            r_state <= w_seed;
        end else if (en) begin
            r_state <= {r_state[WIDTH-2:0], w_fb};
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/lfsr_piece_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_piece_gen
// Purpose  : LFSR with req/ack rejection sampler returning 0..RANGE-1.
//            Optional macro LFSR_PIECE_NO_REPEAT_EN rerolls a repeat once.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_piece_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_16),
    parameter int               RANGE     = 7,
    parameter int               MAX_TRIES = 4,
    localparam int              OUT_W     = (clog2(RANGE) < 1) ? 1 : clog2(RANGE)
) (
    input  logic             clk,
    input  logic             data_A,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic             ack,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             rnd_valid,
    output logic [OUT_W-1:0] rnd_value,
    output logic             busy
);

    localparam int               TRY_W    = (clog2(MAX_TRIES) < 1) ? 1 : clog2(MAX_TRIES);
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [OUT_W:0]   RANGE_V  = (OUT_W + 1)'(RANGE);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [TRY_W-1:0] r_tries;
    logic [OUT_W-1:0] r_value;
    logic [OUT_W-1:0] w_cand;
    logic [OUT_W-1:0] w_forced;
    logic             w_in_range;
    logic             w_last_try;
    logic             w_reroll;
    logic             w_accept;
    logic             w_force;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk       (clk),
        .data_A    (data_A),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .state     (lfsr_out)
    );

    assign w_cand     = lfsr_out[OUT_W-1:0];
    assign w_in_range = {1'b0, w_cand} < RANGE_V;
    assign w_last_try = (r_tries == LAST_TRY);
    // RANGE > 2^(OUT_W-1) keeps cand - RANGE inside 0..RANGE-1.
    assign w_forced   = w_cand - RANGE_V[OUT_W-1:0];

`ifdef LFSR_PIECE_NO_REPEAT_EN
    logic [OUT_W-1:0] r_last;
    logic             r_rerolled;

    assign w_reroll = w_in_range && (w_cand == r_last) && !r_rerolled && !w_last_try;

    always_ff @(posedge clk or posedge data_A) begin
        if (data_A) begin
            r_last     <= '0;
            r_rerolled <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && req) r_rerolled <= 1'b0;
            if (r_state == ST_SAMPLE && w_reroll) r_rerolled <= 1'b1;
            if (r_state == ST_HOLD && ack) r_last <= r_value;
        end
    end
`else
    assign w_reroll = 1'b0;
`endif

    assign w_accept = w_in_range && !w_reroll;
    assign w_force  = !w_in_range && w_last_try;

    always_ff @(posedge clk or posedge data_A) begin
        if (data_A) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (req) w_next = ST_SAMPLE;
            ST_SAMPLE: if (w_accept || w_force) w_next = ST_HOLD;
            ST_HOLD:   if (ack) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rnd_valid = (r_state == ST_HOLD);
        busy      = (r_state != ST_IDLE);
        rnd_value = r_value;
    end

    always_ff @(posedge clk or posedge data_A) begin
        if (data_A) begin
            r_tries <= '0;
            r_value <= '0;
        end else begin
            if (r_state == ST_IDLE && req) begin
                r_tries <= '0;
            end else if (r_state == ST_SAMPLE) begin
                if (w_accept)     r_value <= w_cand;
                else if (w_force) r_value <= w_forced;
                else              r_tries <= r_tries + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_piece_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_piece_gen
// Purpose  : Directed and randomized checks of lfsr_piece_gen against a
//            behavioural model of the generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_piece_gen;

    localparam int          WIDTH     = 16;
    localparam logic [15:0] TAPS      = 16'hB400;
    localparam int          RANGE     = 7;
    localparam int          MAX_TRIES = 4;
    localparam int          OUT_W     = 3;

    logic              clk = 1'b0;
    logic              data_A = 1'b1;
    logic              en = 1'b0;
    logic              seed_load = 1'b0;
    logic [WIDTH-1:0]  seed_in = '0;
    logic              req = 1'b0;
    logic              ack = 1'b0;
    logic [WIDTH-1:0]  lfsr_out;
    logic              rnd_valid;
    logic [OUT_W-1:0]  rnd_value;
    logic              busy;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: waiting/delivered flags instead of an encoded state.
    int unsigned m_lfsr;
    bit          m_waiting;
    bit          m_delivered;
    int          m_tries;
    int unsigned m_val;
    int unsigned m_last;
    bit          m_rerolled;

    lfsr_piece_gen #(
        .WIDTH     (WIDTH),
        .TAPS      (TAPS),
        .RANGE     (RANGE),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk       (clk),
        .data_A    (data_A),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .ack       (ack),
        .lfsr_out  (lfsr_out),
        .rnd_valid (rnd_valid),
        .rnd_value (rnd_value),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 0; m_waiting = 0; m_delivered = 0;
        m_tries = 0; m_val = 0; m_last = 0; m_rerolled = 0;
    endtask

    task automatic model_step();
        int unsigned cand;
        int unsigned nxt;
        bit          reroll;
        cand = m_lfsr % (1 << OUT_W);
        if (seed_load)
            nxt = (seed_in == 16'hFFFF) ? 0 : 32'(seed_in);
        else if (en)
            nxt = ((m_lfsr * 2) % 65536) + (($countones(m_lfsr & 32'(TAPS)) % 2 == 0) ? 1 : 0);
        else
            nxt = m_lfsr;
        reroll = 0;
`ifdef LFSR_PIECE_NO_REPEAT_EN
        reroll = (cand < RANGE) && (cand == m_last) && !m_rerolled && (m_tries < MAX_TRIES - 1);
`endif
        if (m_delivered) begin
            if (ack) begin
                m_delivered = 0;
                m_last = m_val;
            end
        end else if (m_waiting) begin
            if (cand < RANGE && !reroll) begin
                m_val = cand; m_waiting = 0; m_delivered = 1;
            end else if (cand >= RANGE && m_tries == MAX_TRIES - 1) begin
                m_val = cand - RANGE; m_waiting = 0; m_delivered = 1;
            end else begin
                m_tries++;
                if (reroll) m_rerolled = 1;
            end
        end else if (req) begin
            m_waiting = 1; m_tries = 0; m_rerolled = 0;
        end
        m_lfsr = nxt;
    endtask

    task automatic compare_model(input string tag);
        check_value({tag, ".lfsr"},  32'(lfsr_out),  m_lfsr);
        check_value({tag, ".valid"}, 32'(rnd_valid), 32'(m_delivered));
        check_value({tag, ".value"}, 32'(rnd_value), m_val);
        check_value({tag, ".busy"},  32'(busy),      32'(m_waiting | m_delivered));
    endtask

    task automatic tick();
        @(posedge clk);
        if (data_A) model_reset();
        else        model_step();
        #1;
    endtask

    task automatic check_zeroed(input string tag);
        check_value({tag, ".lfsr"},  32'(lfsr_out),  0);
        check_value({tag, ".valid"}, 32'(rnd_valid), 0);
        check_value({tag, ".value"}, 32'(rnd_value), 0);
        check_value({tag, ".busy"},  32'(busy),      0);
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_load = 1; seed_in = s; en = 0;
        tick();
        seed_load = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        check_zeroed("reset");
        tick(); tick();
        data_A = 0;

        // Free-running sequence from zero.
        en = 1;
        tick(); check_value("step1", 32'(lfsr_out), 32'h0001);
        tick(); check_value("step2", 32'(lfsr_out), 32'h0003);
        tick(); check_value("step3", 32'(lfsr_out), 32'h0007);
        for (int i = 4; i <= 12; i++) tick();
        check_value("step12", 32'(lfsr_out), 32'h0FFE);

        load_seed(16'hFFFF);
        check_value("lockup_guard", 32'(lfsr_out), 32'h0000);

        // Accept on first evaluation.
        load_seed(16'h0005);
        req = 1; tick(); req = 0;
        check_value("acc_n1_valid", 32'(rnd_valid), 0);
        check_value("acc_n1_busy", 32'(busy), 1);
        tick();
        check_value("acc_n2_valid", 32'(rnd_valid), 1);
        check_value("acc_n2_value", 32'(rnd_value), 5);
        tick(); tick();
        check_value("acc_hold_valid", 32'(rnd_valid), 1);
        check_value("acc_hold_value", 32'(rnd_value), 5);
        ack = 1; req = 1; tick(); ack = 0; req = 0;
        check_value("acc_ack_busy", 32'(busy), 0);
        check_value("acc_ack_valid", 32'(rnd_valid), 0);

        // Forced delivery after MAX_TRIES rejections.
        load_seed(16'h0007);
        req = 1; tick(); req = 0;
        for (int i = 2; i <= 4; i++) tick();
        check_value("force_n4_valid", 32'(rnd_valid), 0);
        tick();
        check_value("force_n5_valid", 32'(rnd_valid), 1);
        check_value("force_n5_value", 32'(rnd_value), 0);
        ack = 1; tick(); ack = 0;

`ifdef LFSR_PIECE_NO_REPEAT_EN
        load_seed(16'h0005);
        req = 1; tick(); req = 0; tick();
        check_value("nr_first_value", 32'(rnd_value), 5);
        ack = 1; tick(); ack = 0;
        req = 1; tick(); req = 0; tick();
        check_value("nr_n2_valid", 32'(rnd_valid), 0);
        tick();
        check_value("nr_n3_valid", 32'(rnd_valid), 1);
        check_value("nr_n3_value", 32'(rnd_value), 5);
        ack = 1; tick(); ack = 0;
`endif

        // Asynchronous reset during SAMPLE.
        load_seed(16'h0007);
        req = 1; tick(); req = 0;
        data_A = 1; #1;
        check_zeroed("rst_sample");
        tick(); data_A = 0;
        req = 1; tick(); req = 0; tick();
        check_value("post_rst_valid", 32'(rnd_valid), 1);
        check_value("post_rst_value", 32'(rnd_value), 0);

        // Asynchronous reset during HOLD.
        data_A = 1; #1;
        check_zeroed("rst_hold");
        tick(); data_A = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            en        = ($urandom % 4) != 0;
            seed_load = ($urandom % 24) == 0;
            seed_in   = (($urandom % 8) == 0) ? 16'hFFFF : 16'($urandom);
            req       = ($urandom % 3) == 0;
            ack       = ($urandom % 3) == 0;
            if (($urandom % 500) == 0) begin
                data_A = 1; #1;
                check_zeroed("rand_rst");
                tick();
                data_A = 0;
            end else begin
                tick();
                compare_model("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
